// File: rtl/somador_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : somador_serial_if
// Description : Handshake/operand bundle for the bit-serial adder.
//               master side drives start, A, B, Cin (and Sub when built with
//               SOMADOR_SERIAL_SUB_EN); slave side drives busy, done, S,
//               Cout, Ovf.
// Ports       : start, A[WIDTH], B[WIDTH], Cin, Sub (optional) -> slave
//               busy, done, S[WIDTH], Cout, Ovf                 -> master
// Revision    : 1.0 - initial release
// ============================================================================
interface somador_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
`ifdef SOMADOR_SERIAL_SUB_EN
  logic             Sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Ovf;

  modport master (
`ifdef SOMADOR_SERIAL_SUB_EN
    output Sub,
`endif
    output start, A, B, Cin,
    input  busy, done, S, Cout, Ovf
  );

  modport slave (
`ifdef SOMADOR_SERIAL_SUB_EN
    input  Sub,
`endif
    input  start, A, B, Cin,
    output busy, done, S, Cout, Ovf
  );
endinterface
`default_nettype wire

// File: rtl/somador_serial.sv
`default_nettype none
// ============================================================================
// Module      : somador_serial
// Description : Bit-serial WIDTH-bit adder. One 1-bit full adder cell is
//               stepped over WIDTH cycles, LSB first, with a registered carry.
//               start/busy/done handshake; S, Cout, Ovf held until the next
//               result is registered.
//               Optional macro SOMADOR_SERIAL_SUB_EN adds the Sub input
//               (A - B via ~B and carry-in forced to 1).
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - somador_serial_if.slave (start, A, B, Cin, [Sub],
//                       busy, done, S, Cout, Ovf)
// Parameters  : WIDTH - operand/result width, 2..32
// Revision    : 1.0 - initial release
// ============================================================================

// Single-bit full adder cell shared by all bit positions.
module somador_serial_fa (
  input  wire logic a,
  input  wire logic b,
  input  wire logic ci,
  output logic      s,
  output logic      co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module somador_serial #(
  parameter int WIDTH = 8
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  somador_serial_if.slave  bus
);
  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] psum;    // sum bits produced so far, newest at the top
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] sum_w;   // psum with this cycle's bit appended on top
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // Operand B and initial carry as loaded on an accepted start.
  always_comb begin
    b_load = bus.B;
    c_load = bus.Cin;
`ifdef SOMADOR_SERIAL_SUB_EN
    if (bus.Sub) begin
      b_load = ~bus.B;
      c_load = 1'b1;
    end
`endif
  end

  somador_serial_fa u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // After WIDTH-1 shifts bit 0 has reached psum[0], so on the last cycle
  // sum_w is the complete result in natural bit order.
  assign sum_w = {fa_s, psum};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      psum     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.S    <= '0;
      bus.Cout <= 1'b0;
      bus.Ovf  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          psum  <= sum_w[WIDTH-1:1];
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            bus.S    <= sum_w;
            bus.Cout <= fa_co;
            // carry FF holds the carry into the MSB during the last bit
            bus.Ovf  <= carry ^ fa_co;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end

        default: begin  // IDLE and DONE both accept a new start
          bus.done <= 1'b0;
          if (bus.start) begin
            a_sr     <= bus.A;
            b_sr     <= b_load;
            carry    <= c_load;
            psum     <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_somador_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_somador_serial
// Description : Self-checking bench for somador_serial. An 8-bit instance
//               runs directed and random operations; a 2-bit instance is
//               swept over every A, B, Cin combination. Expected results
//               come from plain integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_somador_serial;
  logic clk;
  logic rst_n;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] prev_s;
  logic       prev_c;
  logic       prev_v;

  somador_serial_if #(.WIDTH(8)) bus8 ();
  somador_serial_if #(.WIDTH(2)) bus2 ();

  somador_serial #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  somador_serial #(.WIDTH(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {Cout,S} = A + B' + c, Ovf when both addends share a sign
  // that differs from the result sign.
  task automatic model8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, output logic [7:0] s, output logic c,
                        output logic v);
    int unsigned bb, cc, full;
    bb   = sub ? ((~b) & 8'hFF) : b;
    cc   = sub ? 1 : cin;
    full = a + bb + cc;
    s    = full[7:0];
    c    = full[8];
    v    = (a[7] == bb[7]) && (s[7] != a[7]);
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub);
    bus8.start = 1'b1;
    bus8.A     = a;
    bus8.B     = b;
    bus8.Cin   = cin;
`ifdef SOMADOR_SERIAL_SUB_EN
    bus8.Sub   = sub;
`else
    if (sub) $display("note: subtract request ignored in add-only build");
`endif
  endtask

  // Waits for done after an accepted start, checking busy and held outputs
  // on each intermediate cycle. drop: release start after acceptance.
  // poke: pulse start mid-run with other operands. Otherwise operands are
  // swapped to a_alt/b_alt while running with start held.
  task automatic wait8(input bit drop, input bit poke, input logic [7:0] a_alt,
                       input logic [7:0] b_alt, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (drop && n == 1) bus8.start = 1'b0;
      if (!drop && n == 1) begin
        bus8.A = a_alt;
        bus8.B = b_alt;
      end
      if (poke && n == 3) begin
        bus8.start = 1'b1;
        bus8.A     = a_alt;
        bus8.B     = b_alt;
      end
      if (poke && n == 4) bus8.start = 1'b0;
      if (!bus8.done) begin
        chk("run_busy", 32'(bus8.busy), 32'd1);
        chk("run_hold_S", 32'(bus8.S), 32'(prev_s));
        chk("run_hold_Cout", 32'(bus8.Cout), 32'(prev_c));
        chk("run_hold_Ovf", 32'(bus8.Ovf), 32'(prev_v));
      end
    end while (!bus8.done && n < 40);
    chk("latency8", 32'(n), 32'd9);
  endtask

  task automatic result8(input logic [7:0] es, input logic ec, input logic ev);
    chk("done_busy", 32'(bus8.busy), 32'd0);
    chk("done_flag", 32'(bus8.done), 32'd1);
    chk("S", 32'(bus8.S), 32'(es));
    chk("Cout", 32'(bus8.Cout), 32'(ec));
    chk("Ovf", 32'(bus8.Ovf), 32'(ev));
    prev_s = es;
    prev_c = ec;
    prev_v = ev;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic sub, input bit poke);
    logic [7:0] es;
    logic       ec, ev;
    int         n;
    model8(a, b, cin, sub, es, ec, ev);
    @(negedge clk);
    drive8(a, b, cin, sub);
    wait8(1'b1, poke, ~a, ~b, n);
    result8(es, ec, ev);
    @(negedge clk);
    chk("done_pulse", 32'(bus8.done), 32'd0);
    chk("idle_busy", 32'(bus8.busy), 32'd0);
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic cin);
    int unsigned full;
    int          n;
    full = a + b + cin;
    @(negedge clk);
    bus2.start = 1'b1;
    bus2.A     = a;
    bus2.B     = b;
    bus2.Cin   = cin;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus2.start = 1'b0;
      if (!bus2.done) chk("w2_busy", 32'(bus2.busy), 32'd1);
    end while (!bus2.done && n < 20);
    chk("latency2", 32'(n), 32'd3);
    chk("w2_sum", 32'({bus2.Cout, bus2.S}), full & 32'h7);
  endtask

  initial begin
    int         n;
    logic [7:0] ra, rb;
    logic       rc, rs;

    rst_n      = 1'b0;
    bus8.start = 1'b0;
    bus8.A     = '0;
    bus8.B     = '0;
    bus8.Cin   = 1'b0;
    bus2.start = 1'b0;
    bus2.A     = '0;
    bus2.B     = '0;
    bus2.Cin   = 1'b0;
`ifdef SOMADOR_SERIAL_SUB_EN
    bus8.Sub   = 1'b0;
    bus2.Sub   = 1'b0;
`endif
    prev_s = '0;
    prev_c = 1'b0;
    prev_v = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_done", 32'(bus8.done), 32'd0);
    chk("rst_S", 32'(bus8.S), 32'd0);
    chk("rst_Cout", 32'(bus8.Cout), 32'd0);
    chk("rst_Ovf", 32'(bus8.Ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy0", 32'(bus8.busy), 32'd0);

    // Directed vectors
    run8(8'h35, 8'h4A, 1'b0, 1'b0, 1'b0);
    chk("tp1_S", 32'(bus8.S), 32'h7F);
    run8(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
    chk("tp2_S", 32'(bus8.S), 32'h01);
    chk("tp2_Cout", 32'(bus8.Cout), 32'd1);
    run8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("tp3_S", 32'(bus8.S), 32'h80);
    chk("tp3_Ovf", 32'(bus8.Ovf), 32'd1);

    // Start pulse during RUN must be ignored
    run8(8'h12, 8'h34, 1'b1, 1'b0, 1'b1);

    // Back-to-back with start held high
    @(negedge clk);
    drive8(8'h10, 8'h20, 1'b0, 1'b0);
    wait8(1'b0, 1'b0, 8'h01, 8'h02, n);
    result8(8'h30, 1'b0, 1'b0);
    wait8(1'b0, 1'b0, 8'h01, 8'h02, n);
    bus8.start = 1'b0;
    result8(8'h03, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_done_low", 32'(bus8.done), 32'd0);
    chk("b2b_idle", 32'(bus8.busy), 32'd0);

    // Asynchronous reset during bit 4
    @(negedge clk);
    drive8(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (5) begin
      @(negedge clk);
      bus8.start = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus8.busy), 32'd0);
    chk("arst_done", 32'(bus8.done), 32'd0);
    chk("arst_S", 32'(bus8.S), 32'd0);
    chk("arst_Cout", 32'(bus8.Cout), 32'd0);
    chk("arst_Ovf", 32'(bus8.Ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_s = '0;
    prev_c = 1'b0;
    prev_v = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(bus8.busy), 32'd0);
    end
    run8(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("post_rst_S", 32'(bus8.S), 32'h02);

`ifdef SOMADOR_SERIAL_SUB_EN
    run8(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
    chk("sub1_S", 32'(bus8.S), 32'hFE);
    chk("sub1_Cout", 32'(bus8.Cout), 32'd0);
    run8(8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
    chk("sub2_S", 32'(bus8.S), 32'h7F);
    chk("sub2_Ovf", 32'(bus8.Ovf), 32'd1);
`endif

    // Random operations
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
`ifdef SOMADOR_SERIAL_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      run8(ra, rb, rc, rs, 1'($urandom_range(0, 1)));
    end

    // 2-bit exhaustive sweep
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++)
          run2(2'(a), 2'(b), 1'(c));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
